unidade_controle: RTL and testbench

Multicycle control unit of the nRisc 8-bit core. It sits directly downstream of the instruction bank and consumes the byte that the bank registers on each posedge. It sequences fetch, decode, execute, memory and write-back through a Moore state machine. It drives the write/read strobes of the PC, register bank and data memory, plus the `Encerra` halt line that freezes the PC.

---
 rtl/unidade_controle.sv | 195 +++++++++++++++++++
 tb/tb_unidade_controle.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle.sv
// unidade_controle -- multicycle Moore control unit of the nRisc 8-bit core.
//
// Each instruction moves through fetch, decode, execute, memory and write-back
// states. Every strobe is decoded from the current state and the latched
// instruction `ir`. The only exception is the BEQ PC load, which is taken
// from `zero` in EXEC.
//
// Ports:
//   clock        system clock, all state updates on posedge
//   reset        asynchronous, active-high; state BUSCA, ir and counter cleared
//   instrucao    registered byte from the instruction bank, valid in ESPERA
//   zero         ALU equality flag, used only in EXEC for BEQ
//   pc_escreve   PC load enable
//   pc_fonte     next-PC select: 00 PC+1, 01 PC+1+sext(ir[2:0]), 10 {000,ir[4:0]}
//   alu_op       00 add, 01 sub
//   EscreveReg   register bank write enable
//   mem_para_reg write-back data comes from memory (LW)
//   imm_para_reg write-back data is zero-extended ir[2:0] (LI)
//   lerMem       data memory read enable
//   EscreverMem  data memory write enable
//   Encerra      halt, freezes the PC
//   estado       current state (debug)
//   ir           latched instruction
//   instr_ret    retired-instruction count (only with CONTADOR_INSTR_EN)
//
// Optional build macro: CONTADOR_INSTR_EN adds the 8-bit instr_ret counter.
module unidade_controle #(
    parameter int LARG_ESTADO = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             instrucao,
    input  logic                   zero,
    output logic                   pc_escreve,
    output logic [1:0]             pc_fonte,
    output logic [1:0]             alu_op,
    output logic                   EscreveReg,
    output logic                   mem_para_reg,
    output logic                   imm_para_reg,
    output logic                   lerMem,
    output logic                   EscreverMem,
    output logic                   Encerra,
    output logic [LARG_ESTADO-1:0] estado,
    output logic [7:0]             ir
`ifdef CONTADOR_INSTR_EN
    ,
    output logic [7:0]             instr_ret
`endif
);

    typedef enum logic [2:0] {
        BUSCA   = 3'd0,
        ESPERA  = 3'd1,
        DECOD   = 3'd2,
        EXEC    = 3'd3,
        MEM     = 3'd4,
        ESCRITA = 3'd5,
        PARADO  = 3'd6
    } estado_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_JMP  = 3'b101;
    localparam logic [2:0] OP_LI   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] PC_MAIS_1 = 2'b00;
    localparam logic [1:0] PC_REL    = 2'b01;
    localparam logic [1:0] PC_ABS    = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    estado_t    atual, prox;
    logic [2:0] opcode;

    assign opcode = ir[7:5];
    assign estado = LARG_ESTADO'(atual);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) atual <= BUSCA;
        else       atual <= prox;
    end

    // The bank output is valid during ESPERA, so it is captured on the edge
    // that leaves ESPERA. Any X in it is kept as-is.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                 ir <= 8'h00;
        else if (atual == ESPERA)  ir <= instrucao;
    end

    // Next state and Moore outputs
    always_comb begin
        prox         = BUSCA;
        pc_escreve   = 1'b0;
        pc_fonte     = PC_MAIS_1;
        alu_op       = ALU_ADD;
        EscreveReg   = 1'b0;
        mem_para_reg = 1'b0;
        imm_para_reg = 1'b0;
        lerMem       = 1'b0;
        EscreverMem  = 1'b0;
        Encerra      = 1'b0;

        case (atual)
            BUSCA: prox = ESPERA;

            // PC advances while the bank output is being captured, so BEQ
            // later adds its offset to PC+1.
            ESPERA: begin
                prox       = DECOD;
                pc_escreve = 1'b1;
                pc_fonte   = PC_MAIS_1;
            end

            DECOD: begin
                case (opcode)
                    OP_LI:   prox = ESCRITA;
                    OP_HALT: prox = PARADO;
                    OP_JMP: begin
                        prox       = BUSCA;
                        pc_escreve = 1'b1;
                        pc_fonte   = PC_ABS;
                    end
                    default: prox = EXEC;
                endcase
            end

            EXEC: begin
                case (opcode)
                    OP_ADD: prox = ESCRITA;
                    OP_SUB: begin
                        prox   = ESCRITA;
                        alu_op = ALU_SUB;
                    end
                    OP_LW, OP_SW: prox = MEM;
                    OP_BEQ: begin
                        prox       = BUSCA;
                        alu_op     = ALU_SUB;
                        pc_escreve = zero;
                        pc_fonte   = PC_REL;
                    end
                    default: prox = BUSCA;
                endcase
            end

            MEM: begin
                if (opcode == OP_LW) begin
                    lerMem = 1'b1;
                    prox   = ESCRITA;
                end else if (opcode == OP_SW) begin
                    EscreverMem = 1'b1;
                    prox        = BUSCA;
                end else begin
                    prox = BUSCA;
                end
            end

            ESCRITA: begin
                prox         = BUSCA;
                EscreveReg   = 1'b1;
                mem_para_reg = (opcode == OP_LW);
                imm_para_reg = (opcode == OP_LI);
            end

            PARADO: begin
                prox    = PARADO;
                Encerra = 1'b1;
            end

            // Encoding 7 is never entered legally; fall back to a fetch.
            default: prox = BUSCA;
        endcase
    end

`ifdef CONTADOR_INSTR_EN
    // An instruction retires when a working state hands control back to
    // BUSCA. HALT never does, and recovery from encoding 7 is not counted.
    logic retira;

    assign retira = (prox == BUSCA) &&
                    ((atual == DECOD) || (atual == EXEC) ||
                     (atual == MEM)   || (atual == ESCRITA));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       instr_ret <= 8'h00;
        else if (retira) instr_ret <= instr_ret + 8'h01;
    end
`endif

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] instrucao;
    logic       zero;
    logic       pc_escreve;
    logic [1:0] pc_fonte;
    logic [1:0] alu_op;
    logic       EscreveReg, mem_para_reg, imm_para_reg, lerMem, EscreverMem, Encerra;
    logic [2:0] estado;
    logic [7:0] ir;
`ifdef CONTADOR_INSTR_EN
    logic [7:0] instr_ret;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [13:0] exp_q[$];
    logic [13:0] VB, VE, VD;

    always #5 clock = ~clock;

    unidade_controle #(.LARG_ESTADO(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .instrucao    (instrucao),
        .zero         (zero),
        .pc_escreve   (pc_escreve),
        .pc_fonte     (pc_fonte),
        .alu_op       (alu_op),
        .EscreveReg   (EscreveReg),
        .mem_para_reg (mem_para_reg),
        .imm_para_reg (imm_para_reg),
        .lerMem       (lerMem),
        .EscreverMem  (EscreverMem),
        .Encerra      (Encerra),
        .estado       (estado),
        .ir           (ir)
`ifdef CONTADOR_INSTR_EN
        ,
        .instr_ret    (instr_ret)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    // Expected output vector: {estado, pc_escreve, pc_fonte, alu_op,
    // EscreveReg, mem_para_reg, imm_para_reg, lerMem, EscreverMem, Encerra}
    function automatic logic [13:0] v(input int st, input int pcw, input int pcf, input int alu,
                                      input int er, input int m2r, input int i2r,
                                      input int rd, input int wr, input int enc);
        return {st[2:0], pcw[0], pcf[1:0], alu[1:0], er[0], m2r[0], i2r[0], rd[0], wr[0], enc[0]};
    endfunction

    function automatic logic [13:0] snap();
        return {estado, pc_escreve, pc_fonte, alu_op, EscreveReg, mem_para_reg,
                imm_para_reg, lerMem, EscreverMem, Encerra};
    endfunction

    // Starts at a negedge inside BUSCA; checks one queued vector per cycle and
    // ends at the negedge of the following BUSCA.
    task automatic run_seq(input string tag, input logic [7:0] ins, input logic z);
        instrucao = ins;
        zero      = z;
        foreach (exp_q[i]) begin
            #1;
            chk($sformatf("%s c%0d", tag, i + 1), {18'b0, snap()}, {18'b0, exp_q[i]});
            @(negedge clock);
        end
        chk({tag, " ir"}, {24'b0, ir}, {24'b0, ins});
        exp_q.delete();
    endtask

    initial begin
        VB = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        VE = v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        VD = v(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        reset     = 1'b1;
        instrucao = 8'h00;
        zero      = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset state", {18'b0, snap()}, {18'b0, VB});
        chk("reset ir", {24'b0, ir}, 32'h0);
`ifdef CONTADOR_INSTR_EN
        chk("reset instr_ret", {24'b0, instr_ret}, 32'h0);
`endif
        reset = 1'b0;

        // ADD r2,r0 with zero high: zero must not matter outside BEQ
        exp_q.push_back(VB); exp_q.push_back(VE); exp_q.push_back(VD);
        exp_q.push_back(v(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(v(5, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        run_seq("ADD", 8'b00010001, 1'b1);

        // LW
        exp_q.push_back(VB); exp_q.push_back(VE); exp_q.push_back(VD);
        exp_q.push_back(v(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(v(4, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        exp_q.push_back(v(5, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        run_seq("LW", 8'b01010010, 1'b0);

        // SUB
        exp_q.push_back(VB); exp_q.push_back(VE); exp_q.push_back(VD);
        exp_q.push_back(v(3, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(v(5, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        run_seq("SUB", 8'b00101010, 1'b0);

        // SW
        exp_q.push_back(VB); exp_q.push_back(VE); exp_q.push_back(VD);
        exp_q.push_back(v(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(v(4, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        run_seq("SW", 8'b01110010, 1'b0);

        // LI
        exp_q.push_back(VB); exp_q.push_back(VE); exp_q.push_back(VD);
        exp_q.push_back(v(5, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        run_seq("LI", 8'b11000101, 1'b0);

        // BEQ taken / not taken
        exp_q.push_back(VB); exp_q.push_back(VE); exp_q.push_back(VD);
        exp_q.push_back(v(3, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        run_seq("BEQ z1", 8'b10010000, 1'b1);
        exp_q.push_back(VB); exp_q.push_back(VE); exp_q.push_back(VD);
        exp_q.push_back(v(3, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        run_seq("BEQ z0", 8'b10010000, 1'b0);

        // JMP 1
        exp_q.push_back(VB); exp_q.push_back(VE);
        exp_q.push_back(v(2, 1, 2, 0, 0, 0, 0, 0, 0, 0));
        run_seq("JMP", 8'b10100001, 1'b0);

        // HALT, then hold in PARADO
        exp_q.push_back(VB); exp_q.push_back(VE); exp_q.push_back(VD);
        exp_q.push_back(v(6, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        run_seq("HALT", 8'b11100000, 1'b1);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("PARADO hold %0d", k), {18'b0, snap()}, {18'b0, v(6, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
            @(negedge clock);
        end

        // Asynchronous reset between clock edges
        #2 reset = 1'b1;
        #1;
        chk("async rst halt", {18'b0, snap()}, {18'b0, VB});
        chk("async rst ir", {24'b0, ir}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Reset while the SW write strobe is up
        exp_q.push_back(VB); exp_q.push_back(VE); exp_q.push_back(VD);
        exp_q.push_back(v(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_seq("SW rst", 8'b01110010, 1'b0);
        #1;
        chk("SW rst pre wr", {31'b0, EscreverMem}, 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("SW rst wr drop", {31'b0, EscreverMem}, 32'h0);
        chk("SW rst estado", {29'b0, estado}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

`ifdef CONTADOR_INSTR_EN
        reset = 1'b1;
        @(negedge clock);
        reset     = 1'b0;
        instrucao = 8'b00010001;
        zero      = 1'b0;
        repeat (5) @(negedge clock);
        chk("cnt after 1", {24'b0, instr_ret}, 32'h1);
        repeat (255 * 5) @(negedge clock);
        chk("cnt wrap", {24'b0, instr_ret}, 32'h0);
        instrucao = 8'b11100000;
        repeat (8) @(negedge clock);
        chk("cnt halt estado", {29'b0, estado}, 32'h6);
        chk("cnt frozen", {24'b0, instr_ret}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
